pipeline_stage_sequencer: RTL
=============================

Name: pipeline_stage_sequencer

Overview:
- Owns the s0..s3 pipeline registers for microcode and instruction data. These registers feed data_dep_detector.
- Consumes the detector's data_dependency result and acts on it: holds s0, injects bubbles into s1, accepts new instructions from decode over a valid/ready handshake, and handles flush.
- Closes the hazard loop: the detector decides, this block enforces.

Parameters:
- MICROCODE_W, 22, microcode word width per stage
- INST_DATA_W, 25, instruction_data width per stage
- MAX_STALL, 3, maximum legal consecutive stall cycles (pipeline depth behind s0)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  sequencer accepts it this cycle
- in_microcode  in  MICROCODE_W  microcode of the presented instruction
- in_instruction_data  in  INST_DATA_W  instruction_data of the presented instruction
- data_dependency  in  1  combinational hazard result computed from this block's own stage outputs
- flush  in  1  kill s0 and any incoming instruction
- microcode_s0..microcode_s3  out  MICROCODE_W each  stage microcode
- instruction_data_s0..instruction_data_s3  out  INST_DATA_W each  stage instruction data
- valid_s0..valid_s3  out  1 each  stage holds a real instruction (not a bubble)
- stalled  out  1  registered; the sequencer is in STALL state
- stall_overrun  out  1  sticky error; stall exceeded MAX_STALL

Behaviour:
- Reset (rst=1 at a clock edge):
  - all stages load MICROCODE_NOP, instruction_data 0, valid 0
  - stalled=0, stall_overrun=0, stall_cnt=0, state RUN
  - in_ready is combinational and is 0 while rst=1
- Bubble definition: microcode = MICROCODE_NOP (all zero). This decodes to reg_write_enable=0 and check_rs1/check_rs2=0, so a bubble never creates or matches a dependency.
- hazard = data_dependency & valid_s0.
- in_ready = !rst & !hazard & !flush.
- Advance cycle (hazard=0):
  - s3<=s2, s2<=s1, s1<=s0
  - s0 <= input if in_valid & in_ready; otherwise s0 <= bubble
  - s3 contents retire and are dropped
- Stall cycle (hazard=1, flush=0):
  - s0 holds
  - s1 <= bubble
  - s2<=s1, s3<=s2
  - the input is not accepted
- Flush (flush=1): takes priority over hazard.
  - s0 <= bubble; the input is not accepted
  - s1 <= bubble if hazard, else s1 <= s0
  - s2 and s3 shift normally
  - state -> RUN, stall_cnt <= 0
- FSM:
  - RUN -> STALL when hazard & !flush
  - STALL -> STALL while hazard & !flush
  - STALL -> RUN when !hazard or flush
  - stalled = (state==STALL)
- stall_cnt:
  - 2-bit counter
  - increments each STALL-entering or STALL-remaining cycle; resets to 0 on RUN
  - saturates at MAX_STALL
  - if hazard is still asserted with stall_cnt==MAX_STALL, stall_overrun <= 1. This case is impossible with a correct detector, because s1..s3 fully drain within 3 bubbles.
- stall_overrun is sticky until rst. The sequencer keeps stalling; it does not force progress.
- Latency: an accepted instruction appears in s0 on the next cycle. Each subsequent stage follows one cycle later unless stalled.
- Back-to-back dependent instructions:
  - a dependency on s1 stalls 3 cycles
  - a dependency on s2 stalls 2 cycles
  - a dependency on s3 stalls 1 cycle
  - in each case the producer leaves s3 before s0 advances
- A reset asserted mid-stall discards all stages on the same edge.
- in_ready must not depend on in_valid (no combinational loop).

Decomposition:
- Shared package pipeline_pkg holds:
  - MICROCODE_W, INST_DATA_W
  - MICROCODE_NOP
  - typedef stage_t {microcode, instruction_data, valid}
  - typedef enum seq_state_t {RUN, STALL}
- Sub-module pipeline_stage_reg: one stage register with load/bubble/hold controls, instantiated 4 times.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> all valid_sN=0, microcode_sN=0, in_ready=0, stalled=0.
- Streaming: 8 independent instructions, in_valid=1, data_dependency=0 -> in_ready=1 every cycle; instruction k appears in s0 at cycle k+1 and in s3 at cycle k+4; no bubbles.
- Dependency on s1: drive data_dependency=1 for 3 cycles -> s0 holds; s1 gets bubbles at cycles 1,2,3; stalled=1 for 3 cycles; stall_cnt reaches 3; stall_overrun=0; s0 advances on cycle 4.
- Dependency on s3 only: data_dependency=1 for 1 cycle -> one bubble in s1; in_ready=0 for exactly 1 cycle.
- Flush during stall: flush=1 on the 2nd stall cycle -> s0 becomes a bubble, valid_s0=0, state RUN, the incoming instruction is dropped, in_ready=0 that cycle.
- Overrun: force data_dependency=1 for 5 cycles with s0 valid -> stall_overrun=1 from cycle 4 and sticky afterwards; cleared only by rst.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the s0..s3 instruction pipeline.
package pipeline_pkg;

    localparam int unsigned MICROCODE_W = 22;
    localparam int unsigned INST_DATA_W = 25;

    // All-zero microcode decodes to no register write and no source checks.
    localparam logic [MICROCODE_W-1:0] MICROCODE_NOP = '0;

    typedef struct packed {
        logic [MICROCODE_W-1:0] microcode;
        logic [INST_DATA_W-1:0] instruction_data;
        logic                   valid;
    } stage_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } seq_state_t;

    localparam stage_t BUBBLE = '{
        microcode:        MICROCODE_NOP,
        instruction_data: '0,
        valid:            1'b0
    };

endpackage

// File: rtl/pipeline_stage_reg.sv
// One pipeline stage register: bubble has priority over load, otherwise hold.
module pipeline_stage_reg
    import pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// Owns stages s0..s3 and enforces the detector's hazard decision:
// holds s0, bubbles s1, gates decode acceptance and applies flush.
module pipeline_stage_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned MAX_STALL = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MICROCODE_W-1:0] in_microcode,
    input  logic [INST_DATA_W-1:0] in_instruction_data,
    input  logic                   data_dependency,
    input  logic                   flush,
    output logic [MICROCODE_W-1:0] microcode_s0,
    output logic [MICROCODE_W-1:0] microcode_s1,
    output logic [MICROCODE_W-1:0] microcode_s2,
    output logic [MICROCODE_W-1:0] microcode_s3,
    output logic [INST_DATA_W-1:0] instruction_data_s0,
    output logic [INST_DATA_W-1:0] instruction_data_s1,
    output logic [INST_DATA_W-1:0] instruction_data_s2,
    output logic [INST_DATA_W-1:0] instruction_data_s3,
    output logic                   valid_s0,
    output logic                   valid_s1,
    output logic                   valid_s2,
    output logic                   valid_s3,
    output logic                   stalled,
    output logic                   stall_overrun
);

    localparam logic [1:0] STALL_LIMIT = 2'(MAX_STALL);

    seq_state_t state;
    logic [1:0] stall_cnt;
    stage_t     st [4];
    stage_t     d  [4];
    logic [3:0] load;
    logic [3:0] bubble;
    logic       hazard_c;
    logic       accept_c;

    // A bubble in s0 can never be the consumer of a hazard.
    assign hazard_c = data_dependency & st[0].valid;
    assign in_ready = !rst & !hazard_c & !flush;
    assign accept_c = in_valid & in_ready;

    always_comb begin
        load   = 4'b1110;
        bubble = 4'b0000;
        d[0]   = '{microcode: in_microcode, instruction_data: in_instruction_data, valid: 1'b1};
        d[1]   = st[0];
        d[2]   = st[1];
        d[3]   = st[2];
        load[0]   = accept_c;
        bubble[0] = flush | (!hazard_c & !accept_c);
        bubble[1] = hazard_c;
    end

    for (genvar i = 0; i < 4; i++) begin : g_stage
        pipeline_stage_reg u_stage (
            .clk    (clk),
            .rst    (rst),
            .load   (load[i]),
            .bubble (bubble[i]),
            .d      (d[i]),
            .q      (st[i])
        );
    end

    // Stall FSM; overrun is sticky and does not force the pipe forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            stall_cnt     <= 2'd0;
            stall_overrun <= 1'b0;
        end else if (flush || !hazard_c) begin
            state     <= RUN;
            stall_cnt <= 2'd0;
        end else begin
            state <= STALL;
            if (stall_cnt == STALL_LIMIT) begin
                stall_overrun <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 2'd1;
            end
        end
    end

    assign stalled = (state == STALL);

    assign microcode_s0        = st[0].microcode;
    assign microcode_s1        = st[1].microcode;
    assign microcode_s2        = st[2].microcode;
    assign microcode_s3        = st[3].microcode;
    assign instruction_data_s0 = st[0].instruction_data;
    assign instruction_data_s1 = st[1].instruction_data;
    assign instruction_data_s2 = st[2].instruction_data;
    assign instruction_data_s3 = st[3].instruction_data;
    assign valid_s0            = st[0].valid;
    assign valid_s1            = st[1].valid;
    assign valid_s2            = st[2].valid;
    assign valid_s3            = st[3].valid;

endmodule
